// File: rtl/serial_shift_unit_pkg.sv
// rtl/serial_shift_unit_pkg.sv - shared mode and state encodings for the serial shifter
package serial_shift_unit_pkg;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_shift_unit_step.sv
// rtl/serial_shift_unit_step.sv - one single-bit shift step for the selected mode
module shift_step
    import serial_shift_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q
);

    // Select the one-bit move; ASR keeps the sign bit, ROL feeds the MSB back in
    always_comb begin
        q = d;
        case (mode)
            MODE_LSL: q = {d[WIDTH-2:0], 1'b0};
            MODE_LSR: q = {1'b0, d[WIDTH-1:1]};
            MODE_ASR: q = {d[WIDTH-1], d[WIDTH-1:1]};
            MODE_ROL: q = {d[WIDTH-2:0], d[WIDTH-1]};
            default:  q = d;
        endcase
    end

endmodule

// File: rtl/serial_shift_unit.sv
// rtl/serial_shift_unit.sv - multi-cycle shifter, one bit per clock, valid/ready on both sides
module serial_shift_unit
    import serial_shift_unit_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    state_t             state;
    logic [WIDTH-1:0]   data_q;
    logic [SHAMT_W-1:0] count_q;
    logic [1:0]         mode_q;
    logic [WIDTH-1:0]   step_d;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .d    (data_q),
        .mode (mode_q),
        .q    (step_d)
    );

    // Handshake and status flags are pure decodes of the state register
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
        out_data  = data_q;
    end

    // Sequencer: latch operand, iterate one step per cycle, hold result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            data_q  <= '0;
            count_q <= '0;
            mode_q  <= MODE_LSL;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        count_q <= in_shamt;
                        mode_q  <= in_mode;
                        state   <= (in_shamt == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    data_q  <= step_d;
                    count_q <= count_q - SHAMT_W'(1);
                    if (count_q == SHAMT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_shift_unit.sv
// tb/tb_serial_shift_unit.sv - scoreboard bench for serial_shift_unit
module tb_serial_shift_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [2:0] in_shamt = 3'd0;
    logic [1:0] in_mode = 2'b00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb_q[$];

    serial_shift_unit #(.WIDTH(8), .SHAMT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
        logic signed [7:0] sd;
        logic [15:0]       dd;
        sd = d;
        dd = {d, d} << (s % 8);
        case (m)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return sd >>> s;
            default: return dd[15:8];
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
        int w;
        in_data  = d;
        in_shamt = s;
        in_mode  = m;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_data  = 8'h5A;
        in_shamt = 3'd5;
        in_mode  = 2'b11;
    endtask

    task automatic run_op(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m, input logic [7:0] exp);
        int cyc;
        logic [7:0] e;
        out_ready = 1'b1;
        sb_q.push_back(exp);
        accept(d, s, m);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            n_checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_window in_ready=%0b busy=%0b required=0/1", in_ready, busy);
            end
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc !== int'(s) + 1) begin
            n_fail++;
            $display("FAIL latency op=%h/%0d/%0d cycles=%0d required=%0d", d, s, m, cyc, int'(s) + 1);
        end
        e = sb_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== e) begin
            n_fail++;
            $display("FAIL result op=%h/%0d/%0d out_valid=%0b out_data=%h required=%h", d, s, m, out_valid, out_data, e);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL return_idle in_ready=%0b out_valid=%0b required=1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state in_ready=%0b out_valid=%0b busy=%0b out_data=%h required=1/0/0/00",
                     in_ready, out_valid, busy, out_data);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lsl();
        run_op(8'h81, 3'd3, 2'b00, 8'h08);
    endtask

    task automatic test_shift_modes();
        run_op(8'h90, 3'd2, 2'b10, 8'hE4);
        run_op(8'h90, 3'd2, 2'b01, 8'h24);
        run_op(8'h70, 3'd7, 2'b10, 8'h00);
        run_op(8'h80, 3'd7, 2'b10, 8'hFF);
        run_op(8'hFF, 3'd7, 2'b00, 8'h80);
    endtask

    task automatic test_rotate();
        run_op(8'h81, 3'd1, 2'b11, 8'h03);
        run_op(8'hA5, 3'd0, 2'b11, 8'hA5);
        run_op(8'h96, 3'd7, 2'b11, 8'h4B);
    endtask

    task automatic test_backpressure();
        int w;
        logic [7:0] e;
        out_ready = 1'b0;
        sb_q.push_back(8'h3C);
        accept(8'hF0, 3'd2, 2'b01);
        w = 0;
        while (!out_valid && w < 20) begin
            tick();
            w++;
        end
        e = sb_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure_hold cyc=%0d out_valid=%0b out_data=%h in_ready=%0b busy=%0b required=1/%h/0/1",
                         i, out_valid, out_data, in_ready, busy, e);
            end
            in_valid = i[0];
            in_data  = 8'h11 + 8'(i);
            in_shamt = 3'd1;
            in_mode  = 2'b00;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== e) begin
            n_fail++;
            $display("FAIL backpressure_final out_valid=%0b out_data=%h required=1/%h", out_valid, out_data, e);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release out_valid=%0b in_ready=%0b busy=%0b required=0/1/0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_mid_op();
        out_ready = 1'b1;
        accept(8'h01, 3'd7, 2'b00);
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_op out_valid=%0b busy=%0b out_data=%h in_ready=%0b required=0/0/00/1",
                     out_valid, busy, out_data, in_ready);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_result cyc=%0d out_valid=%0b required=0", i, out_valid);
            end
            tick();
        end
        run_op(8'h01, 3'd1, 2'b00, 8'h02);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d[2];
        logic [2:0] s[2];
        logic [1:0] m[2];
        logic [7:0] e;
        int idx, got, cons_cyc, acc1_cyc;
        logic acc, cons;
        for (int rep = 0; rep < 4; rep++) begin
            for (int k = 0; k < 2; k++) begin
                d[k] = 8'($urandom);
                s[k] = 3'($urandom_range(0, 7));
                m[k] = 2'($urandom_range(0, 3));
            end
            out_ready = 1'b1;
            idx = 0;
            got = 0;
            cons_cyc = -1;
            acc1_cyc = -1;
            in_valid = 1'b1;
            in_data  = d[0];
            in_shamt = s[0];
            in_mode  = m[0];
            for (int cyc = 0; cyc < 60 && got < 2; cyc++) begin
                acc  = in_valid && in_ready;
                cons = out_valid && out_ready;
                if (cons) begin
                    e = sb_q.pop_front();
                    n_checks++;
                    if (out_data !== e) begin
                        n_fail++;
                        $display("FAIL b2b_result rep=%0d n=%0d out_data=%h required=%h", rep, got, out_data, e);
                    end
                    if (got == 0) cons_cyc = cyc;
                    got++;
                end
                if (acc) begin
                    sb_q.push_back(model(d[idx], s[idx], m[idx]));
                    if (idx == 1) acc1_cyc = cyc;
                    idx++;
                end
                tick();
                if (idx == 1) begin
                    in_data  = d[1];
                    in_shamt = s[1];
                    in_mode  = m[1];
                end else if (idx == 2) begin
                    in_valid = 1'b0;
                end
            end
            in_valid = 1'b0;
            n_checks++;
            if (got !== 2) begin
                n_fail++;
                $display("FAIL b2b_timeout rep=%0d results=%0d required=2", rep, got);
            end
            n_checks++;
            if (acc1_cyc !== cons_cyc + 1) begin
                n_fail++;
                $display("FAIL b2b_accept_slot rep=%0d accept_cycle=%0d required=%0d", rep, acc1_cyc, cons_cyc + 1);
            end
            sb_q.delete();
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_lsl();
        test_shift_modes();
        test_rotate();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_shift_unit.md
Name: serial_shift_unit

Overview:
- Multi-cycle shift engine that performs one single-bit shift step per clock. Supported modes are logical left, logical right, arithmetic right and rotate left.
- It is the sequential counterpart of the combinational shift-operator block. It sits downstream of the operand source and upstream of the result consumer.
- Operands enter and results leave through valid/ready handshakes.
- It is used where a full barrel shifter is too costly and shift latency is acceptable.

Parameters:
- WIDTH, 8, data width in bits (minimum 2).
- SHAMT_W, 3, shift-amount width. Shift amounts range 0 .. 2^SHAMT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand presented.
- in_ready  output  1  unit can accept an operand.
- in_data  input  WIDTH  operand (two's complement for arithmetic mode).
- in_shamt  input  SHAMT_W  shift amount.
- in_mode  input  2  00 = LSL, 01 = LSR, 10 = ASR, 11 = ROL.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (asynchronous, takes effect immediately regardless of clk):
  - state = IDLE.
  - Data register, count register and mode register = 0.
  - out_valid = 0, busy = 0, in_ready = 1 (combinational from IDLE).
  - A reset mid-operation discards the operation in flight; no result is produced.
- States: IDLE, SHIFT, DONE (2-bit encoding).
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_data, in_shamt and in_mode.
  - If in_shamt == 0, go to DONE; otherwise go to SHIFT.
- SHIFT: each cycle apply one step to the data register and decrement count.
  - LSL: {d[W-2:0], 0}.
  - LSR: {0, d[W-1:1]}.
  - ASR: {d[W-1], d[W-1:1]} (sign bit replicated).
  - ROL: {d[W-2:0], d[W-1]}.
  - When count == 1 at the clock edge, apply the final step and go to DONE.
- DONE:
  - out_valid = 1, out_data = data register.
  - Both are held stable while out_ready = 0.
  - On out_ready = 1, go to IDLE.
  - No bypass: a new operand is never accepted in the same cycle a result is consumed.
- Latency: for shift amount N, out_valid rises N+1 cycles after the accepting edge. For N = 0 it rises 1 cycle after.
- in_ready = 0 in SHIFT and DONE; in_valid is ignored there.
- out_data is a registered value in all states. out_valid is decoded from state == DONE.
- Shift amounts ≥ WIDTH (possible when 2^SHAMT_W > WIDTH) are fully iterated:
  - LSL and LSR give 0.
  - ASR gives all copies of the sign bit.
  - ROL wraps modulo WIDTH.
- The count register is SHAMT_W bits wide. The maximum shift amount does not overflow it.
- in_* signals are sampled only on the accepting edge; later changes have no effect.

Decomposition:
- Shared package holds:
  - Mode constants MODE_LSL = 2'b00, MODE_LSR = 2'b01, MODE_ASR = 2'b10, MODE_ROL = 2'b11.
  - State encodings ST_IDLE, ST_SHIFT, ST_DONE.
- One sub-module, shift_step: purely combinational. Inputs are d[WIDTH] and mode[2]; output is the single-step result. It is instantiated once in the SHIFT datapath.
- The FSM, count register and handshakes remain in serial_shift_unit.

Test Plan (WIDTH = 8, SHAMT_W = 3):
1. LSL 0x81, shamt 3, out_ready = 1 → out_valid 4 cycles after accept, out_data = 0x08. in_ready = 0 throughout, back to 1 the cycle after consumption.
2. ASR 0x90, shamt 2 → 0xE4. LSR 0x90, shamt 2 → 0x24. ASR 0x70, shamt 7 → 0x00. ASR 0x80, shamt 7 → 0xFF.
3. ROL 0x81, shamt 1 → 0x03. ROL 0xA5, shamt 0 → 0xA5 with out_valid 1 cycle after accept.
4. Backpressure: out_ready held 0 for 5 cycles in DONE → out_valid and out_data stable. in_valid pulses during this window are ignored (no state change). Raising out_ready → IDLE next cycle.
5. Reset mid-operation: assert rst 2 cycles into an LSL by 7 → immediately out_valid = 0, busy = 0, out_data = 0x00, in_ready = 1. After release, a new LSL 0x01 by 1 → 0x02.
6. Back-to-back: two operands offered with continuous in_valid and out_ready = 1 → both results delivered in order. The second is accepted only on the cycle after the first result is consumed.
